vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Generates 640x480 @ 60 Hz VGA timing from the 50 MHz board clock. It produces a 25 MHz pixel-tick enable, horizontal and vertical pixel coordinates, active-low sync pulses and a display-enable flag. It sits directly upstream of the RGB output stage, which uses `video_on` to gate its colour register onto the 8-bit DAC and may use `x`, `y` and `p_tick` for pixel generation. It also emits a one-clock `frame_start` strobe so downstream logic can latch per-frame state.

## Interface

Parameters:
- `H_DISPLAY`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch in pixels
- `H_SYNC`, 96, hsync pulse width in pixels
- `H_BACK`, 48, horizontal back porch in pixels
- `V_DISPLAY`, 480, visible lines per frame
- `V_FRONT`, 10, vertical front porch in lines
- `V_SYNC`, 2, vsync pulse width in lines
- `V_BACK`, 33, vertical back porch in lines

Ports:
- `clk`  in  1  50 MHz system clock
- `reset`  in  1  asynchronous, active-high
- `hsync`  out  1  horizontal sync, active-low, registered
- `vsync`  out  1  vertical sync, active-low, registered
- `video_on`  out  1  high while `x` and `y` are both in the visible area
- `p_tick`  out  1  pixel enable, high one `clk` cycle out of every two
- `x`  out  10  current pixel column, 0..799
- `y`  out  10  current line, 0..524
- `frame_start`  out  1  one-`clk` pulse when the counters wrap to (0,0)

Reset is `reset`, asynchronous, active-high; the clock is `clk`.

## Operation

- **Pixel tick.** A 1-bit toggle register `mod2` resets to 0 and inverts on every `clk` edge. `p_tick = mod2`.
- **Horizontal counter.** `H_TOTAL = 800`. The 10-bit `h_cnt` advances only when `p_tick` is high. At 799 it wraps to 0; otherwise it increments.
- **Vertical counter.** `V_TOTAL = 525`. The 10-bit `v_cnt` advances only when `p_tick` is high and `h_cnt == 799`. At 524 it wraps to 0; otherwise it increments.
- **Coordinates.** `x = h_cnt` and `y = v_cnt`, driven directly from the registers.
- **Horizontal sync.** `hsync` is low iff `h_cnt` is in [656, 751], i.e. [`H_DISPLAY+H_FRONT`, `H_DISPLAY+H_FRONT+H_SYNC-1`].
  - The register is loaded from the *next* counter value, so `hsync` always matches the current `h_cnt` with zero skew.
- **Vertical sync.** `vsync` is low iff `v_cnt` is in [490, 491], computed the same way as `hsync`.
- **Display enable.** `video_on = (h_cnt < 640) && (v_cnt < 480)`. It is combinational from the registered counters.
- **Frame strobe.** `frame_start` is registered. It is high for exactly one `clk` cycle: the cycle after the edge where `p_tick` is high, `h_cnt == 799` and `v_cnt == 524`. That is the first cycle in which `x == 0` and `y == 0`.
- **Counter guard.** Counters never hold values ≥ `H_TOTAL` / `V_TOTAL`. Any out-of-range value wraps to 0 on the next tick.

## Timing

- **Reset values** (all asynchronous): `mod2=0`, `h_cnt=0`, `v_cnt=0`, `hsync=1`, `vsync=1`, `frame_start=0`. Therefore `p_tick=0`, `x=0`, `y=0`, and `video_on=1` while reset is held.
- **First tick after reset release.** The first rising edge sets `p_tick=1`. The second edge advances `x` to 1.
- **Horizontal timing.**
  - One pixel lasts 2 `clk` cycles.
  - One line lasts 1600 `clk` cycles.
  - `hsync` low lasts 192 `clk` cycles.
- **Vertical timing.**
  - One frame lasts 840 000 `clk` cycles.
  - `vsync` low lasts 3200 `clk` cycles.
- **Alignment.** `x`, `y`, `hsync`, `vsync` and `video_on` all change on the same `clk` edge. Downstream RGB stages add their own single register; the resulting one-cycle skew against sync is accepted.
- **Reset mid-frame.** All state returns to its reset values immediately, with no partial-line completion. After release, counting restarts from (0,0). No `frame_start` is emitted for this restart.
- **`frame_start` cadence.** Never asserted in two consecutive cycles. Period is exactly 840 000 `clk` cycles.

## Test plan

- **Reset state.** Assert `reset` for 5 cycles → `hsync=1`, `vsync=1`, `x=0`, `y=0`, `p_tick=0`, `video_on=1`, `frame_start=0`. Release → `p_tick` reads 1,0,1,0…; `x` reaches 1 after 2 `clk`s and 5 after 10 `clk`s.
- **Line timing.** Run 1 line →
  - `hsync` falls when `x` becomes 656, stays low 192 `clk`s, rises at `x=752`.
  - `video_on` falls at `x=640`.
  - `x` wraps 799→0 while `y` goes 0→1; the wrap recurs every 1600 `clk`s.
- **Frame timing.** Run 1 full frame →
  - `vsync` falls at `y=490` and stays low for exactly 3200 `clk`s.
  - `y` wraps 524→0.
  - `frame_start` pulses once, 840 000 `clk`s after the previous pulse, with `x=0` and `y=0` in that cycle.
- **Display-enable count.** Count `p_tick && video_on` over one frame → 307 200. Count `p_tick` over one frame → 420 000.
- **Reset mid-frame.** Assert `reset` asynchronously (not on a `clk` edge) when `x=700`, `y=300` → outputs reach their reset values before the next `clk` edge. After release, the next `frame_start` arrives exactly 840 000 `clk`s later.
- **Parameter override.** Instantiate with `H_DISPLAY=8`, `H_FRONT=1`, `H_SYNC=2`, `H_BACK=1`, `V_DISPLAY=4`, `V_FRONT=1`, `V_SYNC=1`, `V_BACK=1` → line is 12 pixels (24 `clk`s), frame is 7 lines (168 `clk`s), `hsync` is low at `x` = 9..10, `vsync` is low at `y=5`.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA timing generator: derives a half-rate pixel tick from the system clock,
// runs horizontal/vertical position counters, and produces zero-skew active-low
// sync pulses, a display-enable flag and a one-clock frame-start strobe.
module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS      = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST   = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST    = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST    = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic       mod2_q, mod2_d;
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       frame_start_q, frame_start_d;
  logic       h_at_end;
  logic       v_at_end;

  // Next-state logic: counters step on the pixel tick; sync flags are decoded
  // from the next counter values so the registered syncs line up with x/y.
  always_comb begin
    mod2_d   = ~mod2_q;
    h_cnt_d  = h_cnt_q;
    v_cnt_d  = v_cnt_q;
    // ">=" also catches any out-of-range value and folds it back to 0
    h_at_end = (h_cnt_q >= H_LAST);
    v_at_end = (v_cnt_q >= V_LAST);
    if (mod2_q) begin
      h_cnt_d = h_at_end ? 10'd0 : h_cnt_q + 10'd1;
      if (h_at_end) begin
        v_cnt_d = v_at_end ? 10'd0 : v_cnt_q + 10'd1;
      end
    end
    hsync_d       = !((h_cnt_d >= HS_FIRST) && (h_cnt_d <= HS_LAST));
    vsync_d       = !((v_cnt_d >= VS_FIRST) && (v_cnt_d <= VS_LAST));
    frame_start_d = mod2_q && h_at_end && v_at_end;
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mod2_q        <= 1'b0;
      h_cnt_q       <= 10'd0;
      v_cnt_q       <= 10'd0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      mod2_q        <= mod2_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign p_tick      = mod2_q;
  assign x           = h_cnt_q;
  assign y           = v_cnt_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;
  assign video_on    = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 instance for reset and
// line timing, a shrunken instance (12x7 total) for frame-level behaviour.
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       reset_s;

  logic       hsync, vsync, video_on, p_tick, frame_start;
  logic [9:0] x, y;
  logic       hsync_s, vsync_s, video_on_s, p_tick_s, frame_start_s;
  logic [9:0] x_s, y_s;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rel_d = 0;
  int rel_s = 0;
  int n;
  int cnt_pt;
  int cnt_vo;

  always #5 clk = ~clk;

  vga_timing_gen dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync),
    .video_on(video_on), .p_tick(p_tick), .x(x), .y(y),
    .frame_start(frame_start)
  );

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) dut_s (
    .clk(clk), .reset(reset_s), .hsync(hsync_s), .vsync(vsync_s),
    .video_on(video_on_s), .p_tick(p_tick_s), .x(x_s), .y(y_s),
    .frame_start(frame_start_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // advance until the default instance has seen t edges since release
  task automatic to_d(input int t);
    while (cyc - rel_d < t) step();
  endtask

  // advance until the small instance has seen t edges since release
  task automatic to_s(input int t);
    while (cyc - rel_s < t) step();
  endtask

  initial begin
    reset   = 1'b1;
    reset_s = 1'b1;
    repeat (5) step();

    // reset state
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_ptick", p_tick, 0);
    chk("rst_video_on", video_on, 1);
    chk("rst_frame_start", frame_start, 0);

    // release default instance on a falling edge
    reset = 1'b0;
    rel_d = cyc;
    to_d(1);  chk("ptick_c1", p_tick, 1); chk("x_c1", x, 0);
    to_d(2);  chk("ptick_c2", p_tick, 0); chk("x_c2", x, 1);
    to_d(3);  chk("ptick_c3", p_tick, 1); chk("x_c3", x, 1);
    to_d(4);  chk("ptick_c4", p_tick, 0); chk("x_c4", x, 2);
    to_d(10); chk("x_c10", x, 5);

    // visible area ends at x=640
    to_d(1279); chk("x_639", x, 639); chk("vo_639", video_on, 1);
    to_d(1280); chk("x_640", x, 640); chk("vo_640", video_on, 0);

    // hsync falls with x=656 and lasts 192 clocks
    to_d(1311); chk("x_655", x, 655); chk("hs_655", hsync, 1);
    to_d(1312); chk("x_656", x, 656); chk("hs_656", hsync, 0);
    n = 0;
    while (hsync == 1'b0 && n < 400) begin
      n++;
      step();
    end
    chk("hs_low_clks", n, 192);
    chk("hs_rise_x", x, 752);

    // line wrap every 1600 clocks
    to_d(1599); chk("wrap1_x_pre", x, 799); chk("wrap1_y_pre", y, 0);
    to_d(1600); chk("wrap1_x", x, 0); chk("wrap1_y", y, 1);
    chk("wrap1_fs", frame_start, 0);
    to_d(3199); chk("wrap2_x_pre", x, 799); chk("wrap2_y_pre", y, 1);
    to_d(3200); chk("wrap2_x", x, 0); chk("wrap2_y", y, 2);

    // small instance: 12 px/line, 7 lines/frame, 168 clocks/frame
    reset_s = 1'b0;
    rel_s = cyc;
    to_s(167); chk("s_fs_pre", frame_start_s, 0); chk("s_x_last", x_s, 11); chk("s_y_last", y_s, 6);
    to_s(168); chk("s_fs", frame_start_s, 1); chk("s_fs_x", x_s, 0); chk("s_fs_y", y_s, 0);

    // one frame of samples from the first frame_start to the next one
    n = 0; cnt_pt = 0; cnt_vo = 0;
    do begin
      if (p_tick_s) cnt_pt++;
      if (p_tick_s && video_on_s) cnt_vo++;
      step();
      n++;
      if (n == 1) chk("s_fs_single", frame_start_s, 0);
    end while (!frame_start_s && n < 400);
    chk("s_frame_period", n, 168);
    chk("s_ptick_count", cnt_pt, 84);
    chk("s_vo_count", cnt_vo, 32);
    chk("s_fs2_x", x_s, 0);
    chk("s_fs2_y", y_s, 0);

    // second frame starts at 336: visible edge, hsync at x=9..10
    to_s(350); chk("s_vo_x7", video_on_s, 1);
    to_s(352); chk("s_x8", x_s, 8); chk("s_vo_x8", video_on_s, 0); chk("s_hs_x8", hsync_s, 1);
    to_s(354); chk("s_x9", x_s, 9); chk("s_hs_x9", hsync_s, 0);
    to_s(357); chk("s_x10", x_s, 10); chk("s_hs_x10", hsync_s, 0);
    to_s(358); chk("s_x11", x_s, 11); chk("s_hs_x11", hsync_s, 1);

    // vsync low only on y=5
    to_s(455); chk("s_y4", y_s, 4); chk("s_vs_y4", vsync_s, 1);
    to_s(456); chk("s_y5", y_s, 5); chk("s_vs_y5", vsync_s, 0);
    to_s(479); chk("s_vs_y5_end", vsync_s, 0);
    to_s(480); chk("s_y6", y_s, 6); chk("s_vs_y6", vsync_s, 1);

    // asynchronous reset mid-frame at x=5, y=2 of the third frame
    to_s(562); chk("s_mid_x", x_s, 5); chk("s_mid_y", y_s, 2);
    #2 reset_s = 1'b1;
    #1;
    chk("s_arst_x", x_s, 0);
    chk("s_arst_y", y_s, 0);
    chk("s_arst_ptick", p_tick_s, 0);
    chk("s_arst_hsync", hsync_s, 1);
    chk("s_arst_vsync", vsync_s, 1);
    chk("s_arst_vo", video_on_s, 1);
    chk("s_arst_fs", frame_start_s, 0);
    step();
    step();
    reset_s = 1'b0;
    rel_s = cyc;
    n = 0;
    while (n < 400) begin
      step();
      n++;
      if (frame_start_s) break;
    end
    chk("s_restart_fs_delay", n, 168);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
